// File: rtl/prbs_checker_if.sv
// Bit-stream and statistics signals between the RX decoder / BER readout and prbs_checker.
// The master side drives the recovered bits. The slave side is the checker.
interface prbs_checker_if;
    logic        data_in;
    logic        data_in_valid;
    logic        clear_counters;
    logic        locked;
    logic        error_pulse;
    logic [31:0] bit_count;
    logic [31:0] err_count;

    modport master (
        output data_in, data_in_valid, clear_counters,
        input  locked, error_pulse, bit_count, err_count
    );

    modport slave (
        input  data_in, data_in_valid, clear_counters,
        output locked, error_pulse, bit_count, err_count
    );
endinterface

// File: rtl/prbs_checker.sv
// Bit-serial PRBS-7 (x^7 + x^6 + 1) checker: self-seeds, qualifies lock on a run of matches,
// then counts checked bits and bit errors, dropping lock when one window holds too many errors.
module prbs_checker #(
    parameter int unsigned LOCK_MATCHES  = 32,
    parameter int unsigned WINDOW_BITS   = 128,
    parameter int unsigned UNLOCK_ERRORS = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    prbs_checker_if.slave bus
);

    typedef enum logic [1:0] {
        S_SEED,
        S_LOCKING,
        S_LOCKED
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [6:0]  r_sr;
    logic [2:0]  r_seed_cnt;
    logic [7:0]  r_match_cnt;
    logic [15:0] r_win_bits;
    logic [15:0] r_win_errs;
    logic        r_error_pulse;
    logic [31:0] r_bit_count;
    logic [31:0] r_err_count;

    logic        w_pred;
    logic        w_miss;
    logic [6:0]  w_sr_seeded;
    logic        w_seed_done;
    logic        w_seed_ok;
    logic        w_lock_done;
    logic [15:0] w_win_bits_inc;
    logic [15:0] w_win_errs_inc;
    logic        w_unlock;
    logic        w_win_end;

    assign w_pred         = r_sr[6] ^ r_sr[5];
    assign w_miss         = bus.data_in ^ w_pred;
    assign w_sr_seeded    = {r_sr[5:0], bus.data_in};
    assign w_seed_done    = (r_seed_cnt == 3'd6);
    assign w_seed_ok      = |w_sr_seeded;
    assign w_lock_done    = !w_miss && (r_match_cnt == 8'(LOCK_MATCHES - 1));
    assign w_win_bits_inc = r_win_bits + 16'd1;
    assign w_win_errs_inc = r_win_errs + 16'(w_miss);
    assign w_unlock       = w_miss && (w_win_errs_inc == 16'(UNLOCK_ERRORS));
    assign w_win_end      = (w_win_bits_inc == 16'(WINDOW_BITS));

    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_SEED;
        else          r_state <= w_next_state;
    end

    // NOTE: default assignment first so no branch leaves w_next_state unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        if (bus.data_in_valid) begin
            case (r_state)
                S_SEED:    if (w_seed_done && w_seed_ok) w_next_state = S_LOCKING;
                S_LOCKING: begin
                    if (w_miss)           w_next_state = S_SEED;
                    else if (w_lock_done) w_next_state = S_LOCKED;
                end
                S_LOCKED:  if (w_unlock) w_next_state = S_SEED;
                default:   w_next_state = S_SEED;
            endcase
        end
    end

    always_comb begin
        bus.locked = (r_state == S_LOCKED);
    end

    // Once locked the generator free-runs on its own prediction, so a channel error costs one count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sr          <= '0;
            r_seed_cnt    <= '0;
            r_match_cnt   <= '0;
            r_win_bits    <= '0;
            r_win_errs    <= '0;
            r_error_pulse <= 1'b0;
        end else begin
            r_error_pulse <= 1'b0;
            if (bus.data_in_valid) begin
                case (r_state)
                    S_SEED: begin
                        r_sr       <= w_sr_seeded;
                        r_seed_cnt <= w_seed_done ? 3'd0 : r_seed_cnt + 3'd1;
                    end
                    S_LOCKING: begin
                        r_sr <= w_sr_seeded;
                        if (w_miss) begin
                            r_match_cnt <= '0;
                            r_seed_cnt  <= '0;
                        end else if (w_lock_done) begin
                            r_match_cnt <= '0;
                            r_win_bits  <= '0;
                            r_win_errs  <= '0;
                        end else begin
                            r_match_cnt <= r_match_cnt + 8'd1;
                        end
                    end
                    S_LOCKED: begin
                        r_sr          <= {r_sr[5:0], w_pred};
                        r_error_pulse <= w_miss;
                        if (w_unlock || w_win_end) begin
                            r_win_bits <= '0;
                            r_win_errs <= '0;
                        end else begin
                            r_win_bits <= w_win_bits_inc;
                            r_win_errs <= w_win_errs_inc;
                        end
                        if (w_unlock) begin
                            r_seed_cnt  <= '0;
                            r_match_cnt <= '0;
                        end
                    end
                    default: r_seed_cnt <= '0;
                endcase
            end
        end
    end

    // Statistics survive unlock/relock; a coincident clear drops the bit being checked.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_count <= '0;
            r_err_count <= '0;
        end else if (bus.clear_counters) begin
            r_bit_count <= '0;
            r_err_count <= '0;
        end else if (bus.data_in_valid && (r_state == S_LOCKED)) begin
            if (r_bit_count != '1)           r_bit_count <= r_bit_count + 32'd1;
            if (w_miss && r_err_count != '1) r_err_count <= r_err_count + 32'd1;
        end
    end

    assign bus.error_pulse = r_error_pulse;
    assign bus.bit_count   = r_bit_count;
    assign bus.err_count   = r_err_count;

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: scenario table, hand-written corner sequences and a
// randomized phase, all compared every cycle against a queue-based reference model.
module tb_prbs_checker;

    localparam int     LOCK_MATCHES  = 32;
    localparam int     WINDOW_BITS   = 128;
    localparam int     UNLOCK_ERRORS = 8;
    localparam longint SAT           = 64'hFFFF_FFFF;

    localparam int MODE_PRBS = 0;
    localparam int MODE_ZERO = 1;
    localparam int MODE_RAND = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    prbs_checker_if bus ();

    prbs_checker #(
        .LOCK_MATCHES (LOCK_MATCHES),
        .WINDOW_BITS  (WINDOW_BITS),
        .UNLOCK_ERRORS(UNLOCK_ERRORS)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int    checks   = 0;
    int    failures = 0;
    string ctx      = "init";

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s: got %0d expected %0d", ctx, name, act, exp);
        end
    endtask

    // Stimulus generator: textbook PRBS-7, seeded 7'h7F.
    logic [6:0] gen;

    // Reference model: prediction taken from the recorded bit history (b[n-7] ^ b[n-6]).
    typedef enum {M_SEED, M_LOCKING, M_LOCKED} mmode_t;
    mmode_t m_mode;
    bit     m_hist[$];
    int     m_run, m_win_n, m_win_e;
    longint m_bits, m_errs;
    bit     m_pulse;

    task automatic model_reset();
        m_mode  = M_SEED;
        m_hist.delete();
        m_run   = 0;
        m_win_n = 0;
        m_win_e = 0;
        m_bits  = 0;
        m_errs  = 0;
        m_pulse = 0;
    endtask

    task automatic model_step(input bit d, input bit v, input bit clr);
        bit pred, miss, any;
        m_pulse = 0;
        if (clr) begin
            m_bits = 0;
            m_errs = 0;
        end
        if (v) begin
            case (m_mode)
                M_SEED: begin
                    m_hist.push_back(d);
                    if (m_hist.size() == 7) begin
                        any = 0;
                        foreach (m_hist[i]) any |= m_hist[i];
                        if (any) m_mode = M_LOCKING;
                        else     m_hist.delete();
                    end
                end
                M_LOCKING: begin
                    pred = m_hist[0] ^ m_hist[1];
                    m_hist.push_back(d);
                    void'(m_hist.pop_front());
                    if (d == pred) begin
                        m_run++;
                        if (m_run == LOCK_MATCHES) begin
                            m_mode  = M_LOCKED;
                            m_run   = 0;
                            m_win_n = 0;
                            m_win_e = 0;
                        end
                    end else begin
                        m_mode = M_SEED;
                        m_run  = 0;
                        m_hist.delete();
                    end
                end
                default: begin
                    pred = m_hist[0] ^ m_hist[1];
                    miss = (d != pred);
                    m_hist.push_back(pred);
                    void'(m_hist.pop_front());
                    m_pulse = miss;
                    if (!clr) begin
                        if (m_bits < SAT)         m_bits++;
                        if (miss && m_errs < SAT) m_errs++;
                    end
                    m_win_n++;
                    if (miss) m_win_e++;
                    if (miss && m_win_e == UNLOCK_ERRORS) begin
                        m_mode  = M_SEED;
                        m_hist.delete();
                        m_run   = 0;
                        m_win_n = 0;
                        m_win_e = 0;
                    end else if (m_win_n == WINDOW_BITS) begin
                        m_win_n = 0;
                        m_win_e = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic step(input bit d, input bit v, input bit clr);
        bus.data_in        = d;
        bus.data_in_valid  = v;
        bus.clear_counters = clr;
        @(posedge clk);
        model_step(d, v, clr);
        @(negedge clk);
        check("locked",      bus.locked,      64'(m_mode == M_LOCKED));
        check("error_pulse", bus.error_pulse, 64'(m_pulse));
        check("bit_count",   bus.bit_count,   m_bits);
        check("err_count",   bus.err_count,   m_errs);
    endtask

    task automatic feed(input int mode, input bit v, input bit flip, input bit clr);
        bit b;
        b = bit'($urandom_range(0, 1));
        if (v) begin
            case (mode)
                MODE_PRBS: begin
                    b   = gen[6] ^ gen[5];
                    gen = {gen[5:0], b};
                end
                MODE_ZERO: b = 1'b0;
                default:   b = bit'($urandom_range(0, 1));
            endcase
            b ^= flip;
        end
        step(b, v, clr);
    endtask

    task automatic do_reset();
        reset_n            = 1'b0;
        bus.data_in        = 1'b0;
        bus.data_in_valid  = 1'b0;
        bus.clear_counters = 1'b0;
        gen                = 7'h7F;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_locked", bus.locked,      0);
        check("rst_pulse",  bus.error_pulse, 0);
        check("rst_bits",   bus.bit_count,   0);
        check("rst_errs",   bus.err_count,   0);
        reset_n = 1'b1;
    endtask

    // Feed n clean bits and return the 1-based index of the first bit after which locked is seen.
    task automatic run_to_lock(input int n, output int lock_at);
        lock_at = 0;
        for (int k = 1; k <= n; k++) begin
            feed(MODE_PRBS, 1'b1, 1'b0, 1'b0);
            if (bus.locked === 1'b1 && lock_at == 0) lock_at = k;
        end
    endtask

    typedef struct {
        string  name;
        int     mode;
        int     valid_period;   // 1 = every cycle, 2 = alternate, 0 = random gaps
        int     n_valid;
        int     exp_lock_at;    // 0 = must never lock
        longint exp_bits;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int     lock_at, pulses, lock_seen;
        bit     never_dropped;

        vecs[0] = '{"clean",      MODE_PRBS, 1, 1039, 39, 1000};
        vecs[1] = '{"gaps_alt",   MODE_PRBS, 2,  139, 39,  100};
        vecs[2] = '{"gaps_rand",  MODE_PRBS, 0,  239, 39,  200};
        vecs[3] = '{"all_zero",   MODE_ZERO, 1,  500,  0,    0};
        vecs[4] = '{"rand_data",  MODE_RAND, 1, 2000,  0,    0};

        foreach (vecs[i]) begin
            ctx = vecs[i].name;
            do_reset();
            lock_at = 0;
            for (int k = 1; k <= vecs[i].n_valid; k++) begin
                if (vecs[i].valid_period == 2) feed(vecs[i].mode, 1'b0, 1'b0, 1'b0);
                if (vecs[i].valid_period == 0)
                    repeat ($urandom_range(0, 2)) feed(vecs[i].mode, 1'b0, 1'b0, 1'b0);
                feed(vecs[i].mode, 1'b1, 1'b0, 1'b0);
                if (bus.locked === 1'b1 && lock_at == 0) lock_at = k;
            end
            check("lock_at",   lock_at,       vecs[i].exp_lock_at);
            check("bits_end",  bus.bit_count, vecs[i].exp_bits);
            check("errs_end",  bus.err_count, 0);
        end

        // One flipped bit after lock: one pulse, one error, lock held.
        ctx = "single";
        do_reset();
        run_to_lock(39, lock_at);
        check("lock_at", lock_at, 39);
        repeat (20) feed(MODE_PRBS, 1'b1, 1'b0, 1'b0);
        pulses = 0;
        feed(MODE_PRBS, 1'b1, 1'b1, 1'b0);
        if (bus.error_pulse === 1'b1) pulses++;
        for (int k = 0; k < 100; k++) begin
            feed(MODE_PRBS, 1'b1, 1'b0, 1'b0);
            if (bus.error_pulse === 1'b1) pulses++;
        end
        check("pulses", pulses,        1);
        check("errs",   bus.err_count, 1);
        check("bits",   bus.bit_count, 121);
        check("locked", bus.locked,    1);

        // Eight flips within 36 bits: unlock on the eighth, then relock 39 clean bits later.
        ctx = "burst";
        do_reset();
        run_to_lock(39, lock_at);
        repeat (10) feed(MODE_PRBS, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 36; i++) begin
            feed(MODE_PRBS, 1'b1, (i % 5) == 0, 1'b0);
            if (i == 30) check("locked_after_7", bus.locked, 1);
        end
        check("locked_after_8", bus.locked,    0);
        check("errs",           bus.err_count, 8);
        check("bits",           bus.bit_count, 46);
        run_to_lock(39, lock_at);
        check("relock_at",  lock_at,       39);
        check("held_bits",  bus.bit_count, 46);
        check("held_errs",  bus.err_count, 8);
        repeat (10) feed(MODE_PRBS, 1'b1, 1'b0, 1'b0);
        check("bits_cont",  bus.bit_count, 56);

        // One error every 20 bits never fills a 128-bit window with eight errors.
        ctx = "spread";
        do_reset();
        run_to_lock(39, lock_at);
        never_dropped = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            feed(MODE_PRBS, 1'b1, (k % 20) == 0, 1'b0);
            if (bus.locked !== 1'b1) never_dropped = 1'b0;
        end
        check("stayed_locked", never_dropped, 1);
        check("errs",          bus.err_count, 10);
        check("bits",          bus.bit_count, 200);

        // Clear coincident with an errored bit: counters zero, pulse still fires.
        ctx = "clear";
        do_reset();
        run_to_lock(39, lock_at);
        repeat (10) feed(MODE_PRBS, 1'b1, 1'b0, 1'b0);
        check("bits_before", bus.bit_count, 10);
        feed(MODE_PRBS, 1'b1, 1'b1, 1'b1);
        check("bits_clr",  bus.bit_count,   0);
        check("errs_clr",  bus.err_count,   0);
        check("pulse_clr", bus.error_pulse, 1);
        feed(MODE_PRBS, 1'b1, 1'b0, 1'b0);
        check("bits_next",  bus.bit_count,   1);
        check("pulse_next", bus.error_pulse, 0);

        // Asynchronous reset while locked with a pulse showing, then relock.
        ctx = "reset_mid";
        do_reset();
        run_to_lock(39, lock_at);
        repeat (5) feed(MODE_PRBS, 1'b1, 1'b0, 1'b0);
        feed(MODE_PRBS, 1'b1, 1'b1, 1'b0);
        check("pulse_pre", bus.error_pulse, 1);
        reset_n = 1'b0;
        #1;
        check("async_locked", bus.locked,      0);
        check("async_pulse",  bus.error_pulse, 0);
        check("async_bits",   bus.bit_count,   0);
        check("async_errs",   bus.err_count,   0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        run_to_lock(39, lock_at);
        check("relock_at", lock_at, 39);

        // Randomized valid gaps, sparse errors and clears against the model.
        ctx = "random";
        do_reset();
        lock_seen = 0;
        for (int c = 0; c < 4000; c++) begin
            feed(MODE_PRBS, $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 499) == 0);
            if (bus.locked === 1'b1) lock_seen = 1;
        end
        check("lock_seen", lock_seen, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
